// File: rtl/isa_pkg.sv
// rtl/isa_pkg.sv - shared ISA constants and fetch FSM state type
package isa_pkg;

    localparam logic [4:0]  LDM_OPCODE = 5'b11001;
    localparam logic [15:0] NOP_WORD   = 16'h0000;

    typedef enum logic [1:0] {
        BOOT0 = 2'd0,
        BOOT1 = 2'd1,
        RUN   = 2'd2,
        IMM   = 2'd3
    } fetch_state_e;

    function automatic logic is_ldm(input logic [15:0] word, input logic [4:0] opcode);
        return word[15:11] == opcode;
    endfunction

endpackage

// File: rtl/fetch_ldm_fsm.sv
// rtl/fetch_ldm_fsm.sv - boot/LDM sequencing FSM with reset-vector and opcode hold registers
module fetch_ldm_fsm #(
    parameter logic [4:0] LDM_OPCODE = isa_pkg::LDM_OPCODE
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] imem_data,
    input  logic        stall,
    input  logic        redirect,
    output logic        in_boot0,
    output logic        in_boot1,
    output logic        in_imm,
    output logic        ldm_first,
    output logic [15:0] hi_hold,
    output logic [15:0] op_hold
);
    import isa_pkg::*;

    fetch_state_e state;
    fetch_state_e state_next;

    assign in_boot0  = (state == BOOT0);
    assign in_boot1  = (state == BOOT1);
    assign in_imm    = (state == IMM);
    assign ldm_first = (state == RUN) && is_ldm(imem_data, LDM_OPCODE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= BOOT0;
            hi_hold <= 16'h0000;
            op_hold <= 16'h0000;
        end else begin
            state <= state_next;
            if (state == BOOT0) begin
                hi_hold <= imem_data;
            end
            if (ldm_first && !stall && !redirect) begin
                op_hold <= imem_data;
            end
        end
    end

    // Redirect beats stall; flush never changes the sequencing, only the IF/ID contents.
    always_comb begin
        state_next = state;
        case (state)
            BOOT0: state_next = BOOT1;
            BOOT1: state_next = RUN;
            RUN: begin
                if (redirect) begin
                    state_next = RUN;
                end else if (!stall && ldm_first) begin
                    state_next = IMM;
                end
            end
            IMM: begin
                if (redirect || !stall) begin
                    state_next = RUN;
                end
            end
            default: state_next = BOOT0;
        endcase
    end

endmodule

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - instruction fetch with reset-vector boot, two-word LDM merge and IF/ID register
module fetch_stage #(
    parameter logic [4:0]  LDM_OPCODE = isa_pkg::LDM_OPCODE,
    parameter logic [15:0] NOP_WORD   = isa_pkg::NOP_WORD
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] imem_addr,
    input  logic [15:0] imem_data,
    input  logic        stall,
    input  logic        flush,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        mem_redirect,
    input  logic [31:0] mem_pc,
    output logic [15:0] instruction,
    output logic [31:0] pc_plus_one,
    output logic [15:0] ldm_value,
    output logic        boot_busy
);
    logic [31:0] pc;
    logic [31:0] pc_inc;
    logic [31:0] target;
    logic        redirect;
    logic        in_boot0;
    logic        in_boot1;
    logic        in_imm;
    logic        ldm_first;
    logic [15:0] hi_hold;
    logic [15:0] op_hold;

    assign redirect = mem_redirect | branch_taken;
    assign target   = mem_redirect ? mem_pc : branch_target;
    assign pc_inc   = pc + 32'd1;

    assign imem_addr = in_boot0 ? 32'd0 : (in_boot1 ? 32'd1 : pc);
    assign boot_busy = in_boot0 | in_boot1;

    fetch_ldm_fsm #(
        .LDM_OPCODE (LDM_OPCODE)
    ) u_fsm (
        .clk       (clk),
        .reset     (reset),
        .imem_data (imem_data),
        .stall     (stall),
        .redirect  (redirect),
        .in_boot0  (in_boot0),
        .in_boot1  (in_boot1),
        .in_imm    (in_imm),
        .ldm_first (ldm_first),
        .hi_hold   (hi_hold),
        .op_hold   (op_hold)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            pc          <= 32'd0;
            instruction <= NOP_WORD;
            pc_plus_one <= 32'd0;
            ldm_value   <= 16'h0000;
        end else if (in_boot1) begin
            pc <= {hi_hold, imem_data};
        end else if (!in_boot0) begin
            if (redirect) begin
                pc          <= target;
                instruction <= NOP_WORD;
                pc_plus_one <= 32'd0;
                ldm_value   <= 16'h0000;
            end else if (!stall) begin
                pc <= pc_inc;
                // The first LDM word goes out as a bubble; its opcode re-emerges with the immediate.
                if (flush || ldm_first) begin
                    instruction <= NOP_WORD;
                    pc_plus_one <= 32'd0;
                    ldm_value   <= 16'h0000;
                end else if (in_imm) begin
                    instruction <= op_hold;
                    pc_plus_one <= pc_inc;
                    ldm_value   <= imem_data;
                end else begin
                    instruction <= imem_data;
                    pc_plus_one <= pc_inc;
                    ldm_value   <= 16'h0000;
                end
            end
        end
    end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameter LDM_OPCODE, default 5'b11001: value of instruction bits [15:11] that marks a two-word LDM instruction.
REQ-002 Parameter NOP_WORD, default 16'h0000: encoding of the bubble instruction.
REQ-003 Port clk, input, 1: the single clock for the block. Reset is synchronous and active-high.
REQ-004 Port reset, input, 1: synchronous active-high reset.
REQ-005 Port imem_addr, output, 32: word address driven to instruction memory; its read data returns combinationally.
REQ-006 Port imem_data, input, 16: instruction memory word at imem_addr.
REQ-007 Port stall, input, 1: hold PC, state and IF/ID register.
REQ-008 Port flush, input, 1: replace the IF/ID contents with a bubble.
REQ-009 Port branch_taken, input, 1: redirect to branch_target.
REQ-010 Port branch_target, input, 32: jump/call target.
REQ-011 Port mem_redirect, input, 1: redirect to mem_pc (RET/RTI/interrupt vector).
REQ-012 Port mem_pc, input, 32: PC value read from memory.
REQ-013 Port instruction, output, 16: IF/ID instruction to decode.
REQ-014 Port pc_plus_one, output, 32: IF/ID address of the word after the instruction.
REQ-015 Port ldm_value, output, 16: IF/ID LDM immediate, aligned with the LDM instruction.
REQ-016 Port boot_busy, output, 1: high while the reset vector is loading.

Function
REQ-017 FSM states: BOOT0, BOOT1, RUN, IMM.
REQ-018 imem_addr: 0 in BOOT0; 1 in BOOT1; PC in RUN and IMM.
REQ-019 BOOT0 -> BOOT1 unconditionally; hi_hold <= imem_data.
REQ-020 BOOT1 -> RUN; PC <= {hi_hold, imem_data}.
REQ-021 During boot, instruction=NOP_WORD; stall, flush and redirects are ignored.
REQ-022 RUN, non-LDM word, no stall: instruction <= imem_data; pc_plus_one <= PC+1; PC <= PC+1; ldm_value <= 0.
REQ-023 RUN, imem_data[15:11]==LDM_OPCODE, no stall: op_hold <= imem_data; instruction <= NOP_WORD; PC <= PC+1; go to IMM.
REQ-024 IMM, no stall: instruction <= op_hold; ldm_value <= imem_data; pc_plus_one <= PC+1; PC <= PC+1; go to RUN.
REQ-025 LDM therefore reaches decode 2 cycles after its first word is addressed, preceded by exactly one bubble.
REQ-026 stall in RUN or IMM: PC, state, op_hold and all IF/ID outputs hold.
REQ-027 Redirect: PC <= target; IF/ID <= {NOP_WORD, 0, 0}; state <= RUN; any pending IMM is abandoned.
REQ-028 Redirect priority: mem_redirect > branch_taken > stall > flush > normal. A redirect overrides stall.
REQ-029 flush without redirect: IF/ID <= bubble (pc_plus_one = 0, ldm_value = 0). PC and state advance as in normal operation, except that in IMM the state returns to RUN and the LDM is dropped.
REQ-030 PC arithmetic is modulo 2^32; 32'hFFFFFFFF+1 wraps to 0.

Reset
REQ-031 On reset: state=BOOT0; PC=0; hi_hold=0; op_hold=0; instruction=NOP_WORD; pc_plus_one=0; ldm_value=0; boot_busy=1; imem_addr=0.
REQ-032 Reset asserted in any state, including mid-IMM, discards all pending work and restarts the boot sequence.

Structure
REQ-033 LDM_OPCODE, NOP_WORD and the FSM state enum live in the shared package isa_pkg.
REQ-034 The FSM and the hold registers form sub-module fetch_ldm_fsm. The IF/ID register and PC register are implemented in fetch_stage.

Verification
REQ-035 Boot: M[0]=16'h0000, M[1]=16'h0020 -> imem_addr=0,1,then 32'h20; boot_busy falls in cycle 3; instruction=NOP_WORD throughout boot.
REQ-036 LDM: M[0x20]=16'hC900, M[0x21]=16'h1234 -> one NOP, then instruction=16'hC900, ldm_value=16'h1234, pc_plus_one=32'h22.
REQ-037 Stall held 3 cycles in IMM -> outputs and PC frozen; the LDM still emerges complete after stall drops.
REQ-038 branch_taken and mem_redirect asserted together in IMM, targets 0x40/0x80 -> PC=0x80, bubble emitted, LDM dropped.
REQ-039 Reset asserted mid-IMM -> next cycle state=BOOT0, imem_addr=0, all outputs at reset values.
REQ-040 PC=32'hFFFFFFFF non-LDM fetch -> pc_plus_one=0, next imem_addr=0.
